// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// With PREFETCH_FAULT_EN defined, each buffered entry also carries its AXI read-error flag.
package fetch_pkg;

  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [31:0] PC_INC    = 32'd4;

  typedef struct packed {
`ifdef PREFETCH_FAULT_EN
    logic        fault;
`endif
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-2 ring with synchronous flush and a registered head entry.
// The head register is reloaded from the ring, the incoming entry, or zero when emptied.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 push,
  input  T                     din,
  input  logic                 pop,
  output T                     dout,
  output logic                 valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  // A push into a full buffer is legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
      if (do_pop)
        dout <= (count > CW'(1)) ? mem[rd_ptr + 1'b1] : (do_push ? din : '0);
      else if (!valid && do_push)
        dout <= din;
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Sequential instruction prefetcher: AXI4-Lite read master feeding an in-order buffer, with redirect.
// Define PREFETCH_FAULT_EN to add instr_fault, the read-error flag of the buffer head.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
`ifdef PREFETCH_FAULT_EN
  output logic        instr_fault,
`endif
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  input  logic        axi_rvalid,
  output logic        axi_rready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   fetch_pc, resp_pc, pend_addr;
  logic          pend_vld, pend_stale;
  logic [OW-1:0] out_cnt, drop_cnt, out_nxt;
  logic [CW-1:0] fifo_cnt;
  logic          issue_ok, ar_hs, r_hs, push, pop;
  fetch_entry_t  push_entry, head;

  assign axi_rready = 1'b1;
  assign r_hs       = axi_rvalid;
  assign ar_hs      = axi_arvalid && axi_arready;

  // Buffer space is reserved at issue: live reads plus buffered entries never exceed the FIFO.
  assign issue_ok = !rst && !branch_taken
                 && (32'(out_cnt - drop_cnt) + 32'(fifo_cnt) < 32'(FIFO_DEPTH))
                 && (32'(out_cnt) < 32'(MAX_OUTSTANDING));

  // Once presented, a request is held in pend_* until accepted, even across a redirect.
  assign axi_arvalid = pend_vld || issue_ok;
  assign axi_araddr  = pend_vld ? pend_addr : fetch_pc;

  assign out_nxt = out_cnt + OW'(ar_hs) - OW'(r_hs);
  assign push    = r_hs && (drop_cnt == '0) && !branch_taken;
  assign pop     = instr_valid && instr_ready && !branch_taken;

  always_comb begin
    push_entry       = '0;
    push_entry.instr = axi_rdata;
    push_entry.pc    = resp_pc;
`ifdef PREFETCH_FAULT_EN
    push_entry.fault = (axi_rresp != RESP_OKAY);
`endif
  end

`ifndef PREFETCH_FAULT_EN
  logic unused_rresp;
  assign unused_rresp = ^axi_rresp;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      resp_pc    <= RESET_PC;
      pend_addr  <= RESET_PC;
      pend_vld   <= 1'b0;
      pend_stale <= 1'b0;
      out_cnt    <= '0;
      drop_cnt   <= '0;
    end else begin
      out_cnt  <= out_nxt;
      pend_vld <= axi_arvalid && !axi_arready;
      if (axi_arvalid && !pend_vld)
        pend_addr <= fetch_pc;

      if (branch_taken) begin
        // Everything already in flight belongs to the old stream; a held request joins it on acceptance.
        fetch_pc   <= branch_target;
        resp_pc    <= branch_target;
        drop_cnt   <= out_nxt;
        pend_stale <= pend_vld && !axi_arready;
      end else begin
        if (ar_hs && !pend_stale)
          fetch_pc <= fetch_pc + PC_INC;
        if (push)
          resp_pc <= resp_pc + PC_INC;
        if (ar_hs)
          pend_stale <= 1'b0;
        drop_cnt <= drop_cnt - OW'(r_hs && (drop_cnt != '0)) + OW'(ar_hs && pend_stale);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head),
    .valid (instr_valid),
    .count (fifo_cnt)
  );

  assign instr = head.instr;
  assign pc    = head.pc;
`ifdef PREFETCH_FAULT_EN
  assign instr_fault = head.fault;
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: in-order AXI slave model, pc scoreboard,
// table-driven redirect runs and hand-written corner-case sequences.
module tb_prefetch_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, branch_taken, instr_valid, instr_ready;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [31:0] branch_target, instr, pc, axi_araddr, axi_rdata;
  logic [1:0]  axi_rresp;
`ifdef PREFETCH_FAULT_EN
  logic        instr_fault;
`endif

  prefetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .instr         (instr),
    .pc            (pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
`ifdef PREFETCH_FAULT_EN
    .instr_fault   (instr_fault),
`endif
    .axi_araddr    (axi_araddr),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rdata     (axi_rdata),
    .axi_rresp     (axi_rresp),
    .axi_rvalid    (axi_rvalid),
    .axi_rready    (axi_rready)
  );

  typedef struct {
    logic [31:0] target;
    int          n;
    int          exp_ars;
    int          exp_pops;
  } vec_t;
  vec_t vecs[5];

  int          n_chk = 0, n_fail = 0, cyc = 0, n_pop = 0, first_valid_cyc = -1, t0 = 0, tb = 0;
  logic [31:0] first_valid_pc = '0;
  logic        r_en = 1'b1, err_en = 1'b0;
  logic [31:0] err_addr = '0;
  logic [31:0] exp_q[$], rq[$], ar_log[$];
  int          ar_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] ar_at(input int i);
    return (i < ar_log.size()) ? ar_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ar_cyc.size()) ? ar_cyc[i] : -1000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: no expected entry left (cycle %0d)", name, cyc);
  endtask

  task automatic refill(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // One clock: drive the R channel, sample at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [31:0] a;
    if (r_en && rq.size() > 0) begin
      a          = rq.pop_front();
      axi_rvalid = 1'b1;
      axi_rdata  = mem_word(a);
      axi_rresp  = (err_en && a == err_addr) ? 2'b10 : 2'b00;
    end else begin
      axi_rvalid = 1'b0;
      axi_rdata  = '0;
      axi_rresp  = '0;
    end
    @(negedge clk);
    if (!rst) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) fail_now("head_pc");
        else chk("head_pc", pc, exp_q[0]);
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          first_valid_pc  = pc;
        end
        if (instr_ready && !branch_taken && exp_q.size() > 0) begin
          chk("instr", instr, mem_word(exp_q[0]));
          void'(exp_q.pop_front());
          n_pop++;
        end
      end
      if (axi_arvalid && axi_arready) begin
        rq.push_back(axi_araddr);
        ar_log.push_back(axi_araddr);
        ar_cyc.push_back(cyc);
      end
      if (branch_taken) refill(branch_target);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_logs();
    ar_log.delete();
    ar_cyc.delete();
    first_valid_cyc = -1;
    n_pop = 0;
  endtask

  // Stale beats are never delivered across a reset: the slave queue is emptied with it.
  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    rq.delete();
    cycle();
    cycle();
    refill(32'h0);
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic chk_hold();
    chk("hold_arvalid", 32'(axi_arvalid), 32'd1);
    chk("hold_araddr", axi_araddr, 32'h0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 10, 10, 8};
    vecs[1] = '{32'h0000_2000,  5,  5, 3};
    vecs[2] = '{32'hFFFF_FFF0, 12, 12, 10};
    vecs[3] = '{32'h0000_0040,  2,  2, 0};
    vecs[4] = '{32'h0000_0080,  1,  1, 0};

    rst = 1'b1; branch_taken = 1'b0; branch_target = '0;
    instr_ready = 1'b1; axi_arready = 1'b1;
    axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = '0;

    // Reset state, then release with a zero-wait slave.
    cycle();
    cycle();
    chk("rst_arvalid", 32'(axi_arvalid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rready", 32'(axi_rready), 32'd1);
    refill(32'h0);
    clear_logs();
    rst = 1'b0;
    t0 = cyc;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) chk("seq_ar", ar_at(i), 32'(4 * i));
    chk("first_ar_cyc", 32'(cyc_at(0) - t0), 32'd0);
    chk("first_valid_lat", 32'(first_valid_cyc - cyc_at(0)), 32'd2);
    chk("first_valid_pc", first_valid_pc, 32'h0);
    repeat (4) cycle();

    // Redirects from steady state: first AR next cycle, full rate afterwards.
    for (int k = 0; k < 5; k++) begin
      branch_taken = 1'b1;
      branch_target = vecs[k].target;
      cycle();
      branch_taken = 1'b0;
      clear_logs();
      repeat (vecs[k].n) cycle();
      chk("tbl_first_ar", ar_at(0), vecs[k].target);
      chk("tbl_ars", 32'(ar_log.size()), 32'(vecs[k].exp_ars));
      chk("tbl_pops", 32'(n_pop), 32'(vecs[k].exp_pops));
    end

    // Address wrap.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    cycle();
    branch_taken = 1'b0;
    clear_logs();
    repeat (4) cycle();
    chk("wrap_ar1", ar_at(1), 32'hFFFF_FFFC);
    chk("wrap_ar2", ar_at(2), 32'h0000_0000);

    // Consumer stalled: the buffer fills, then one pop frees exactly one AR.
    instr_ready = 1'b0;
    do_reset();
    repeat (10) cycle();
    chk("bp_ars", 32'(ar_log.size()), 32'd4);
    chk("bp_arvalid", 32'(axi_arvalid), 32'd0);
    chk("bp_valid", 32'(instr_valid), 32'd1);
    chk("bp_head_pc", pc, 32'h0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    ar_log.delete();
    ar_cyc.delete();
    repeat (6) cycle();
    chk("bp_one_ar", 32'(ar_log.size()), 32'd1);
    chk("bp_next_addr", ar_at(0), 32'h10);

    // Redirect with two reads outstanding: both beats are dropped.
    instr_ready = 1'b1;
    r_en = 1'b0;
    do_reset();
    repeat (3) cycle();
    chk("br_pre_ars", 32'(ar_log.size()), 32'd2);
    branch_taken = 1'b1; branch_target = 32'h100;
    cycle();
    branch_taken = 1'b0;
    r_en = 1'b1;
    clear_logs();
    tb = cyc;
    repeat (6) cycle();
    chk("br_first_ar", ar_at(0), 32'h100);
    chk("br_ar_cyc", 32'(cyc_at(0) - tb), 32'd1);
    chk("br_valid_cyc", 32'(first_valid_cyc - tb), 32'd3);
    chk("br_first_pc", first_valid_pc, 32'h100);

    // Redirect while an AR is held by arready=0: old address holds, its beat is dropped.
    axi_arready = 1'b0;
    do_reset();
    cycle();
    chk_hold();
    branch_taken = 1'b1; branch_target = 32'h200;
    cycle();
    branch_taken = 1'b0;
    chk_hold();
    cycle();
    chk_hold();
    cycle();
    chk_hold();
    axi_arready = 1'b1;
    clear_logs();
    tb = cyc;
    repeat (5) cycle();
    chk("stale_ar", ar_at(0), 32'h0);
    chk("stale_ar_cyc", 32'(cyc_at(0) - tb), 32'd0);
    chk("tgt_ar", ar_at(1), 32'h200);
    chk("tgt_ar_cyc", 32'(cyc_at(1) - tb), 32'd1);
    chk("tgt_valid_cyc", 32'(first_valid_cyc - tb), 32'd3);
    chk("tgt_first_pc", first_valid_pc, 32'h200);

`ifdef PREFETCH_FAULT_EN
    // Error response on the second beat: flagged only while that entry is the head.
    instr_ready = 1'b0;
    err_en = 1'b1;
    err_addr = 32'h4;
    do_reset();
    repeat (6) cycle();
    chk("fault_head0", 32'(instr_fault), 32'd0);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    chk("fault_pc", pc, 32'h4);
    chk("fault_head1", 32'(instr_fault), 32'd1);
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    chk("fault_head2", 32'(instr_fault), 32'd0);
    err_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
